// File: rtl/wb_pkg.sv
// wb_pkg: definitions shared by the posted-write buffer and its CAM FIFO.
//   - AW_DEF / DW_DEF     : address and data widths of the cache and RAM (20/32)
//   - MEM_WR_CYCLES_DEF   : default length of a RAM write strobe in cycles
//   - wb_state_t          : drain FSM encoding (IDLE, WRITE, GAP)
//   - cyc_cnt_w()         : width of the counter that times one RAM write
package wb_pkg;

  localparam int AW_DEF            = 20;
  localparam int DW_DEF            = 32;
  localparam int MEM_WR_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } wb_state_t;

  // A counter over 0..cycles-1 needs at least one bit, even for single-cycle writes.
  function automatic int cyc_cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/wb_cam_fifo.sv
// wb_cam_fifo: circular FIFO of (address, data) entries with an associative
// lookup that returns the youngest valid entry matching a read address.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   push, push_addr/data: enqueue request (ignored when full)
//   pop                 : dequeue head (ignored when empty)
//   head_addr/head_data : oldest entry
//   full, count         : occupancy
//   lookup_addr         : forwarding search key
//   lookup_hit/data     : youngest match, data forced to 0 on a miss
module wb_cam_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [AW-1:0]          push_addr,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [AW-1:0]          head_addr,
  output logic [DW-1:0]          head_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  input  logic [AW-1:0]          lookup_addr,
  output logic                   lookup_hit,
  output logic [DW-1:0]          lookup_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    addr_mem [DEPTH];
  logic [DW-1:0]    data_mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count_r;
  logic             push_en;
  logic             pop_en;
  logic [PW-1:0]    idx;
  logic             match;

  assign full      = (count_r == CW'(DEPTH));
  assign push_en   = push && !full;
  assign pop_en    = pop && (count_r != '0);
  assign count     = count_r;
  assign head_addr = addr_mem[head];
  assign head_data = data_mem[head];

  // Pointers, occupancy and valid bits; push and pop never hit the same slot
  // because that would need the buffer to be both empty and full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
      valid   <= '0;
    end else begin
      if (push_en) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      if (pop_en) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload; valid bits qualify it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      addr_mem[tail] <= push_addr;
      data_mem[tail] <= push_data;
    end
  end

  // Youngest-match search: walk oldest to youngest so later hits override.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    match       = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx         = head + PW'(i);
      match       = valid[idx] && (addr_mem[idx] == lookup_addr);
      lookup_hit  = lookup_hit | match;
      lookup_data = match ? data_mem[idx] : lookup_data;
    end
  end

endmodule

// File: rtl/write_buffer.sv
// write_buffer: posted-write buffer between a write-through cache and RAM.
// Queues up to DEPTH writes, drains them one at a time with a one-cycle
// strobe-low gap, and forwards the newest buffered data to read misses.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   wr_req/wr_addr/wr_data      : push from cache, accepted when wr_ready
//   rd_req/rd_addr              : pending read miss; blocks a new drain start
//   fwd_hit/fwd_data            : combinational forwarding result
//   mem_addr/mem_wdata/mem_wr   : registered RAM write port
//   mem_own                     : buffer owns the RAM port (WRITE or GAP)
//   count, drained              : occupancy and write-fence indication
module write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int AW            = AW_DEF,
  parameter int DW            = DW_DEF,
  parameter int MEM_WR_CYCLES = MEM_WR_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_req,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DW-1:0]          wr_data,
  output logic                   wr_ready,
  input  logic                   rd_req,
  input  logic [AW-1:0]          rd_addr,
  output logic                   fwd_hit,
  output logic [DW-1:0]          fwd_data,
  output logic [AW-1:0]          mem_addr,
  output logic [DW-1:0]          mem_wdata,
  output logic                   mem_wr,
  output logic                   mem_own,
  output logic [$clog2(DEPTH):0] count,
  output logic                   drained
);

  localparam int             CYW      = cyc_cnt_w(MEM_WR_CYCLES);
  localparam logic [CYW-1:0] LAST_CYC = CYW'(MEM_WR_CYCLES - 1);

  wb_state_t      state;
  wb_state_t      state_nx;
  logic [CYW-1:0] cyc;
  logic           last_cyc;
  logic           pop;
  logic           full;
  logic           has_work;
  logic [AW-1:0]  head_addr;
  logic [DW-1:0]  head_data;

  wb_cam_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (wr_req),
    .push_addr   (wr_addr),
    .push_data   (wr_data),
    .pop         (pop),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .full        (full),
    .count       (count),
    .lookup_addr (rd_addr),
    .lookup_hit  (fwd_hit),
    .lookup_data (fwd_data)
  );

  assign wr_ready = !full;
  assign last_cyc = (cyc == LAST_CYC);
  // The head stays buffered (and forwardable) until its last strobe cycle.
  assign pop      = (state == WRITE) && last_cyc;
  assign has_work = (count != '0) && !rd_req;
  assign mem_own  = (state == WRITE) || (state == GAP);
  assign drained  = (count == '0) && (state == IDLE);

  // Drain FSM next state; a started write always runs to completion.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = has_work ? WRITE : IDLE;
      WRITE:   state_nx = last_cyc ? GAP : WRITE;
      GAP:     state_nx = has_work ? WRITE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, strobe timer and registered RAM port; head is latched on WRITE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cyc       <= '0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_nx;
      cyc    <= ((state == WRITE) && !last_cyc) ? cyc + CYW'(1) : '0;
      mem_wr <= (state_nx == WRITE);
      if ((state != WRITE) && (state_nx == WRITE)) begin
        mem_addr  <= head_addr;
        mem_wdata <= head_data;
      end
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
// tb_write_buffer: directed and randomized checks of write_buffer against a
// queue-based model of posted writes (FIFO order, youngest-match forwarding,
// count = accepted pushes - completed RAM writes).
module tb_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 20;
  localparam int DW    = 32;
  localparam int MWC   = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr;
  logic          mem_own;
  logic [CW-1:0] count;
  logic          drained;

  write_buffer #(
    .DEPTH(DEPTH), .AW(AW), .DW(DW), .MEM_WR_CYCLES(MWC)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_own(mem_own),
    .count(count), .drained(drained)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  int total = 0;
  int bad   = 0;

  // RAM-side observations: one entry per write, its strobe length and the
  // strobe-low cycles preceding it.
  ent_t obs_q[$];
  int   len_q[$];
  int   gap_q[$];
  int   hi_len = 0;
  int   lo_len = 0;

  // Model: every accepted push, in order.
  ent_t mq[$];

  always @(negedge clk) begin
    ent_t e;
    if (rst) begin
      if (hi_len != 0) len_q.push_back(hi_len);
      hi_len = 0;
      lo_len = 0;
    end else if (mem_wr) begin
      if (hi_len == 0) begin
        e.a = mem_addr;
        e.d = mem_wdata;
        obs_q.push_back(e);
        gap_q.push_back(lo_len);
      end
      hi_len++;
      lo_len = 0;
    end else begin
      if (hi_len != 0) len_q.push_back(hi_len);
      hi_len = 0;
      lo_len++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drained(input string tag);
    int n = 0;
    while (!drained && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, drained, 1'b1);
  endtask

  // Compare RAM writes from obs index base against the model, oldest first.
  task automatic check_writes(input string tag, input int base, input int first, input bit exact_gap);
    int n = obs_q.size() - base;
    check({tag, "_nwr"}, n, mq.size() - first);
    for (int k = 0; k < n && (first + k) < mq.size(); k++) begin
      check($sformatf("%s_addr%0d", tag, k), obs_q[base+k].a, mq[first+k].a);
      check($sformatf("%s_data%0d", tag, k), obs_q[base+k].d, mq[first+k].d);
      if (base + k < len_q.size())
        check($sformatf("%s_len%0d", tag, k), len_q[base+k], MWC);
      else
        check($sformatf("%s_len%0d", tag, k), 0, MWC);
      if (exact_gap && k > 0)
        check($sformatf("%s_gap%0d", tag, k), gap_q[base+k], 1);
    end
  endtask

  // Youngest buffered entry matching addr among mq[lo..size-1].
  task automatic ref_fwd(input int lo, input logic [AW-1:0] addr,
                         output logic hit, output logic [DW-1:0] data);
    hit  = 1'b0;
    data = '0;
    for (int k = mq.size() - 1; k >= lo; k--) begin
      if (!hit && mq[k].a == addr) begin
        hit  = 1'b1;
        data = mq[k].d;
      end
    end
  endtask

  task automatic push_entry(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ent_t e;
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    e.a = a;
    e.d = d;
    mq.push_back(e);
    tick();
    wr_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    int   done;
    int   pushed;
    int   len_base;
    int   n;
    int   live;
    logic ehit;
    logic [DW-1:0] edata;
    ent_t e;

    rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0; rd_req = 1'b0; rd_addr = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    // Reset state
    check("rst_count", count, 0);
    check("rst_drained", drained, 1'b1);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_own", mem_own, 1'b0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_fwd_hit", fwd_hit, 1'b0);
    check("rst_fwd_data", fwd_data, 0);
    tick();
    check("idle_drained", drained, 1'b1);

    // Single push: strobe two cycles, one GAP, then drained
    mq.delete();
    push_entry(20'd100, 32'd10);
    check("sp_count", count, 1);
    check("sp_no_wr_yet", mem_wr, 1'b0);
    check("sp_not_drained", drained, 1'b0);
    tick();
    check("sp_wr1", mem_wr, 1'b1);
    check("sp_addr", mem_addr, 100);
    check("sp_data", mem_wdata, 10);
    check("sp_own", mem_own, 1'b1);
    tick();
    check("sp_wr2", mem_wr, 1'b1);
    tick();
    check("sp_gap_wr", mem_wr, 1'b0);
    check("sp_gap_own", mem_own, 1'b1);
    check("sp_gap_count", count, 0);
    tick();
    check("sp_idle_own", mem_own, 1'b0);
    check("sp_done", drained, 1'b1);

    // Fill with rd_req held: fifth push refused, then FIFO-order drain
    mq.delete();
    rd_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_req  = 1'b1;
      wr_addr = AW'($urandom_range(0, 1023));
      wr_data = $urandom;
      check($sformatf("fill_ready%0d", i), wr_ready, (mq.size() != DEPTH));
      if (mq.size() != DEPTH) begin
        e.a = wr_addr;
        e.d = wr_data;
        mq.push_back(e);
      end
      tick();
      check($sformatf("fill_count%0d", i), count, mq.size());
    end
    wr_req = 1'b0;
    check("fill_full", wr_ready, 1'b0);
    check("fill_no_own", mem_own, 1'b0);
    base   = obs_q.size();
    rd_req = 1'b0;
    wait_drained("fill");
    check_writes("fill", base, 0, 1'b1);

    // Forwarding: youngest match, same-cycle push invisible
    mq.delete();
    rd_req  = 1'b1;
    rd_addr = 20'd25;
    wr_req  = 1'b1; wr_addr = 20'd25; wr_data = 32'd1;
    #1;
    check("fwd_same_cycle", fwd_hit, 1'b0);
    push_entry(20'd25, 32'd1);
    check("fwd_first_hit", fwd_hit, 1'b1);
    check("fwd_first_data", fwd_data, 1);
    push_entry(20'd25, 32'd7);
    push_entry(20'd30, 32'd3);
    #1;
    check("fwd25_hit", fwd_hit, 1'b1);
    check("fwd25_data", fwd_data, 7);
    rd_addr = 20'd26;
    #1;
    check("fwd26_hit", fwd_hit, 1'b0);
    check("fwd26_data", fwd_data, 0);
    for (int i = 0; i < 6; i++) begin
      rd_addr = AW'($urandom_range(24, 31));
      #1;
      ref_fwd(0, rd_addr, ehit, edata);
      check($sformatf("fwd_rand_hit%0d", i), fwd_hit, ehit);
      check($sformatf("fwd_rand_data%0d", i), fwd_data, edata);
    end
    base   = obs_q.size();
    rd_req = 1'b0;
    tick();
    rd_addr = 20'd25;
    #1;
    check("fwd_inwrite_data", fwd_data, 7);
    n = 0;
    while (!(mem_wr && mem_addr == 20'd30) && n < 50) begin
      tick();
      n++;
    end
    rd_addr = 20'd30;
    #1;
    check("fwd_head_hit", fwd_hit, 1'b1);
    check("fwd_head_data", fwd_data, 3);
    wait_drained("fwd");
    check("fwd_after_hit", fwd_hit, 1'b0);
    check_writes("fwd", base, 0, 1'b1);

    // Push on the final WRITE cycle while count=2
    mq.delete();
    rd_req = 1'b1;
    push_entry(AW'($urandom_range(0, 1023)), $urandom);
    push_entry(AW'($urandom_range(0, 1023)), $urandom);
    base   = obs_q.size();
    rd_req = 1'b0;
    tick();
    check("pp_writing", mem_wr, 1'b1);
    for (int i = 0; i < MWC - 1; i++) tick();
    check("pp_count_before", count, 2);
    push_entry(AW'($urandom_range(0, 1023)), $urandom);
    check("pp_count_after", count, 2);
    wait_drained("pp");
    check_writes("pp", base, 0, 1'b1);

    // Randomized traffic covering several pointer wraps
    mq.delete();
    base     = obs_q.size();
    len_base = len_q.size();
    pushed   = 0;
    n        = 0;
    while (pushed < 3 * DEPTH + 2 && n < 3000) begin
      wr_req  = ($urandom_range(0, 2) != 0);
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = $urandom;
      rd_req  = ($urandom_range(0, 4) == 0);
      rd_addr = AW'($urandom_range(0, 7));
      @(negedge clk);
      #1;
      done = len_q.size() - len_base;
      live = pushed - done;
      check("rnd_count", count, live);
      check("rnd_ready", wr_ready, (live != DEPTH));
      ref_fwd(done, rd_addr, ehit, edata);
      check("rnd_fwd_hit", fwd_hit, ehit);
      check("rnd_fwd_data", fwd_data, edata);
      if (wr_req && live != DEPTH) begin
        e.a = wr_addr;
        e.d = wr_data;
        mq.push_back(e);
        pushed++;
      end
      @(posedge clk);
      #1;
      n++;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    check("rnd_progress", (pushed >= 3 * DEPTH + 2), 1'b1);
    wait_drained("rnd");
    check_writes("rnd", base, 0, 1'b0);

    // Read priority: rd_req during WRITE lets it finish, then holds the drain
    push_entry(20'd200, 32'hAAAA);
    push_entry(20'd201, 32'hBBBB);
    rd_req = 1'b1;
    check("prio_wr", mem_wr, 1'b1);
    check("prio_addr", mem_addr, 200);
    tick();
    check("prio_not_aborted", mem_wr, 1'b1);
    tick();
    check("prio_gap_wr", mem_wr, 1'b0);
    check("prio_gap_own", mem_own, 1'b1);
    check("prio_gap_count", count, 1);
    tick();
    check("prio_idle_own", mem_own, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("prio_hold_wr%0d", i), mem_wr, 1'b0);
      check($sformatf("prio_hold_count%0d", i), count, 1);
    end
    rd_req = 1'b0;
    tick();
    check("prio_resume_wr", mem_wr, 1'b1);
    check("prio_resume_addr", mem_addr, 201);
    check("prio_resume_data", mem_wdata, 32'hBBBB);
    wait_drained("prio");

    // Reset asserted mid-WRITE
    push_entry(20'd300, 32'd1);
    push_entry(20'd301, 32'd2);
    check("mid_wr", mem_wr, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_wr", mem_wr, 1'b0);
    check("mid_rst_own", mem_own, 1'b0);
    check("mid_rst_count", count, 0);
    check("mid_rst_drained", drained, 1'b1);
    tick();
    rst     = 1'b0;
    rd_addr = 20'd300;
    tick();
    check("post_rst_wr", mem_wr, 1'b0);
    check("post_rst_count", count, 0);
    check("post_rst_fwd", fwd_hit, 1'b0);
    check("post_rst_ready", wr_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/write_buffer.md
# write_buffer

Posted-write buffer between the direct-mapped, write-through cache controller and the word-addressed main RAM. Accepts cache write-throughs in one cycle, queues up to DEPTH of them, and drains them to RAM one at a time with a deasserted-strobe gap between writes. Forwards the newest buffered data for a read address so a cache read miss never returns stale RAM contents. Read misses take priority over starting a new drain.

## Interface
- DEPTH, 4: entries; power of two, at least 2
- AW, 20: word-address width
- DW, 32: data width
- MEM_WR_CYCLES, 2: cycles mem_wr is held high per write; at least 1
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_req  in  1  push request from cache controller
- wr_addr  in  AW  push address
- wr_data  in  DW  push data
- wr_ready  out  1  buffer can accept a push; push occurs when wr_req && wr_ready
- rd_req  in  1  cache read miss pending; blocks the start of a new drain
- rd_addr  in  AW  read-miss address for forwarding lookup
- fwd_hit  out  1  rd_addr matches a buffered entry (combinational)
- fwd_data  out  DW  data of the newest matching entry; 0 when no hit
- mem_addr  out  AW  RAM write address (registered)
- mem_wdata  out  DW  RAM write data (registered)
- mem_wr  out  1  RAM write strobe (registered)
- mem_own  out  1  buffer owns the RAM port (states WRITE and GAP)
- count  out  $clog2(DEPTH)+1  occupied entries
- drained  out  1  count==0 and FSM in IDLE; write fence for software/test

## Operation
- Storage is a circular FIFO with head/tail pointers, a valid bit per entry and an age order given by the pointers.
- wr_ready = (count != DEPTH). No same-cycle bypass when full.
- Drain FSM states and transitions:
  - IDLE -> WRITE when count>0 && !rd_req.
  - WRITE: mem_addr/mem_wdata hold the head entry and mem_wr=1 for exactly MEM_WR_CYCLES cycles. rd_req does not abort WRITE.
  - On the last WRITE cycle edge, pop the head and go to GAP.
  - GAP: one cycle with mem_wr=0 and mem_own=1. Go to WRITE if count>0 && !rd_req, otherwise go to IDLE.
- Simultaneous push and pop: count is unchanged and both take effect.
- No coalescing. Duplicate addresses are written in order.
- Forwarding:
  - Compare rd_addr against all valid entries, including the head while it is in WRITE.
  - Select the youngest match.
  - A push in the same cycle is not visible until the next cycle.
- Pointers wrap modulo DEPTH. count saturates by construction: a push at DEPTH is refused and a pop at 0 cannot occur.

## Timing
- Reset values: count=0, drained=1, wr_ready=1, fwd_hit=0, fwd_data=0, mem_wr=0, mem_own=0, mem_addr=0, mem_wdata=0, FSM=IDLE, all valid bits clear.
- Push to mem_wr rising, empty buffer, rd_req low: push at edge E, WRITE entered at edge E+1, mem_wr high from E+1.
- Drain throughput: one write per MEM_WR_CYCLES+1 cycles.
- rd_req sampled high in IDLE or GAP: the drain waits. Deassertion allows WRITE at the next edge.
- Reset asserted mid-WRITE:
  - mem_wr and mem_own drop immediately, asynchronously.
  - All buffered entries are discarded.
  - The RAM may have captured the partial write; this is acceptable.
- fwd_hit/fwd_data are combinational from rd_addr and registered state, with no added latency.

## Structure
- Shared package wb_pkg:
  - AW/DW defaults matching the cache and RAM (20/32).
  - The FSM state encoding IDLE/WRITE/GAP.
  - The MEM_WR_CYCLES counter width.
- One sub-module, wb_cam_fifo: the entry array, pointers, count, and youngest-match forwarding search.
- The write_buffer top holds the drain FSM, the write-cycle counter and the registered RAM outputs.

## Test plan
- Reset then idle: count=0, drained=1, mem_wr=0, wr_ready=1. Assert rst mid-WRITE: mem_wr drops the same cycle and count returns to 0.
- Single push: addr=100, data=10.
  - mem_wr is high for 2 cycles with mem_addr=100, mem_wdata=10.
  - One GAP cycle follows, then drained=1.
- Fill: 5 back-to-back pushes with DEPTH=4 and rd_req held high.
  - wr_ready is low after the 4th push and the 5th is not accepted.
  - Release rd_req: 4 RAM writes occur in FIFO order.
  - Each write is separated by one mem_wr=0 cycle.
- Forwarding: push (25,1), then (25,7), then (30,3); rd_addr=25 gives fwd_hit=1, fwd_data=7; rd_addr=26 gives fwd_hit=0, fwd_data=0.
- Simultaneous push and pop:
  - With count=2, push on the final WRITE cycle; count stays 2.
  - The new entry drains last, and pointer wrap is exercised over 3×DEPTH pushes.
- Read priority: rd_req asserted during WRITE.
  - The current write completes.
  - The next write does not start until rd_req falls, then starts at the following edge.
